// File: rtl/mips_pipeline_chain_pkg.sv
// Shared definitions for the MIPS pipeline-register chain.
//   REG_ZERO      : architectural $zero, never a forwarding source
//   log2 / idx_w  : ceiling log2 and stage-index width (at least 1 bit)
//   MPC_* macros  : slot field layout, {write, dest, payload} with payload in the LSBs
`ifndef MPC_SLOT_MACROS
`define MPC_SLOT_MACROS
`define MPC_SLOT_W(W, R)        ((W) + (R) + 1)
`define MPC_PAYLOAD(s, W, R)    s[(W)-1:0]
`define MPC_DEST(s, W, R)       s[(W)+(R)-1:(W)]
`define MPC_WRITE(s, W, R)      s[(W)+(R)]
`endif

package mips_pipeline_pkg;

    localparam int REG_ZERO = 0;

    // Ceiling log2: log2(1)=0, log2(4)=2, log2(5)=3.
    function automatic int log2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // A single-stage chain still needs a 1-bit index port.
    function automatic int idx_w(input int depth);
        return (log2(depth) < 1) ? 1 : log2(depth);
    endfunction

endpackage

// File: rtl/mips_pipeline_chain_if.sv
// Bus bundle for the pipeline chain: the producer side (in*), consumer side
// (out*), per-stage flush and the two scoreboard/forwarding lookup ports.
//   slave  : the chain itself
//   master : whatever drives the chain (core control / testbench)
interface mips_pipeline_chain_if
    import mips_pipeline_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int REG_W = 5
) ();
    localparam int IDX_W = idx_w(DEPTH);

    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inData;
    logic [REG_W-1:0] inDest;
    logic             inWrite;

    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outData;
    logic [REG_W-1:0] outDest;
    logic             outWrite;

    logic [DEPTH-1:0] flush;

    logic [REG_W-1:0] srcA;
    logic [REG_W-1:0] srcB;
    logic             hitA;
    logic             hitB;
    logic [WIDTH-1:0] fwdA;
    logic [WIDTH-1:0] fwdB;
    logic [IDX_W-1:0] stageA;
    logic [IDX_W-1:0] stageB;

    modport slave (
        input  inValid, inData, inDest, inWrite, outReady, flush, srcA, srcB,
        output inReady, outValid, outData, outDest, outWrite,
               hitA, hitB, fwdA, fwdB, stageA, stageB
    );

    modport master (
        output inValid, inData, inDest, inWrite, outReady, flush, srcA, srcB,
        input  inReady, outValid, outData, outDest, outWrite,
               hitA, hitB, fwdA, fwdB, stageA, stageB
    );
endinterface

// File: rtl/mips_pipeline_chain_slot.sv
// One stage of the pipeline chain: valid bit plus packed slot word.
//   load     : stage advances this cycle (take upstream valid/data)
//   up_valid : upstream effective valid (or inValid for stage 0)
//   up_data  : upstream slot word
//   flush    : kill the current occupant
//   eff      : valid & !flush, the only view of validity used elsewhere
//   data     : stored slot word
module mips_pipeline_slot #(
    parameter int SLOT_W = 38
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              load,
    input  logic              up_valid,
    input  logic [SLOT_W-1:0] up_data,
    input  logic              flush,
    output logic              eff,
    output logic [SLOT_W-1:0] data
);
    logic valid;

    assign eff = valid & ~flush;

    // Holding uses eff, so a flush on a stalled stage still empties it.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= up_valid;
            data  <= up_data;
        end else begin
            valid <= eff;
        end
    end
endmodule

// File: rtl/mips_pipeline_chain.sv
// Elastic, flushable pipeline-register chain with scoreboard lookup.
//   clock, resetN : rising-edge clock, async active-low reset
//   bus (slave)   : in* producer handshake, out* consumer handshake,
//                   flush[DEPTH], srcA/srcB lookups -> hit/fwd/stage
// Stage 0 is the input end, stage DEPTH-1 the output end. Lookups return
// the youngest (lowest-index) live writer of the queried register.
module mips_pipeline_chain
    import mips_pipeline_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int REG_W = 5,
    parameter int IDX_W = idx_w(DEPTH)
) (
    input logic                  clock,
    input logic                  resetN,
    mips_pipeline_chain_if.slave bus
);
    localparam int SLOT_W = `MPC_SLOT_W(WIDTH, REG_W);

    logic [DEPTH-1:0]             eff;
    logic [DEPTH-1:0]             adv;
    logic [DEPTH-1:0]             up_vld;
    logic [DEPTH-1:0][SLOT_W-1:0] up_data;
    logic [DEPTH-1:0][SLOT_W-1:0] slot_q;

    // Ready ripples back from the output: a stage moves if it is empty
    // (after flush) or the stage ahead of it moves.
    assign adv[DEPTH-1] = ~eff[DEPTH-1] | bus.outReady;
    assign up_vld[0]    = bus.inValid;
    assign up_data[0]   = {bus.inWrite, bus.inDest, bus.inData};

    genvar g;
    generate
        for (g = 1; g < DEPTH; g++) begin : g_link
            assign adv[g-1]   = ~eff[g-1] | adv[g];
            assign up_vld[g]  = eff[g-1];
            assign up_data[g] = slot_q[g-1];
        end

        for (g = 0; g < DEPTH; g++) begin : g_slot
            mips_pipeline_slot #(.SLOT_W(SLOT_W)) u_slot (
                .clock    (clock),
                .resetN   (resetN),
                .load     (adv[g]),
                .up_valid (up_vld[g]),
                .up_data  (up_data[g]),
                .flush    (bus.flush[g]),
                .eff      (eff[g]),
                .data     (slot_q[g])
            );
        end
    endgenerate

    assign bus.inReady  = adv[0];
    assign bus.outValid = eff[DEPTH-1];
    assign bus.outData  = `MPC_PAYLOAD(slot_q[DEPTH-1], WIDTH, REG_W);
    assign bus.outDest  = `MPC_DEST(slot_q[DEPTH-1], WIDTH, REG_W);
    assign bus.outWrite = `MPC_WRITE(slot_q[DEPTH-1], WIDTH, REG_W);

    // Per-stage candidates; $zero is excluded up front.
    logic [DEPTH-1:0] cand_a;
    logic [DEPTH-1:0] cand_b;

    generate
        for (g = 0; g < DEPTH; g++) begin : g_cand
            assign cand_a[g] = eff[g] & `MPC_WRITE(slot_q[g], WIDTH, REG_W)
                             & (`MPC_DEST(slot_q[g], WIDTH, REG_W) == bus.srcA)
                             & (bus.srcA != REG_W'(REG_ZERO));
            assign cand_b[g] = eff[g] & `MPC_WRITE(slot_q[g], WIDTH, REG_W)
                             & (`MPC_DEST(slot_q[g], WIDTH, REG_W) == bus.srcB)
                             & (bus.srcB != REG_W'(REG_ZERO));
        end
    endgenerate

    logic             hit_a;
    logic             hit_b;
    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;
    logic [IDX_W-1:0] stage_a;
    logic [IDX_W-1:0] stage_b;

    // Scan oldest to youngest so the lowest matching index wins last.
    always_comb begin
        hit_a   = 1'b0;
        hit_b   = 1'b0;
        fwd_a   = '0;
        fwd_b   = '0;
        stage_a = '0;
        stage_b = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cand_a[i]) begin
                hit_a   = 1'b1;
                fwd_a   = slot_q[i][WIDTH-1:0];
                stage_a = IDX_W'(i);
            end
            if (cand_b[i]) begin
                hit_b   = 1'b1;
                fwd_b   = slot_q[i][WIDTH-1:0];
                stage_b = IDX_W'(i);
            end
        end
    end

    assign bus.hitA   = hit_a;
    assign bus.hitB   = hit_b;
    assign bus.fwdA   = fwd_a;
    assign bus.fwdB   = fwd_b;
    assign bus.stageA = stage_a;
    assign bus.stageB = stage_b;
endmodule

// File: tb/tb_mips_pipeline_chain.sv
// Directed bench for mips_pipeline_chain (WIDTH=32, DEPTH=4, REG_W=5).
module tb_mips_pipeline_chain;
    logic clock;
    logic resetN;
    int   n_chk;
    int   n_err;

    mips_pipeline_chain_if #(.WIDTH(32), .DEPTH(4), .REG_W(5)) bus ();

    mips_pipeline_chain #(.WIDTH(32), .DEPTH(4), .REG_W(5)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [4:0] r, input logic w, input logic v);
        bus.inData  = d;
        bus.inDest  = r;
        bus.inWrite = w;
        bus.inValid = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        resetN       = 1'b0;
        bus.inValid  = 1'b0;
        bus.inData   = '0;
        bus.inDest   = '0;
        bus.inWrite  = 1'b0;
        bus.outReady = 1'b0;
        bus.flush    = '0;
        bus.srcA     = 5'd8;
        bus.srcB     = 5'd0;
        #2;
        chk("rst_ovld", 32'(bus.outValid), 32'd0);
        chk("rst_irdy", 32'(bus.inReady), 32'd1);
        chk("rst_hita", 32'(bus.hitA), 32'd0);
        chk("rst_fwda", bus.fwdA, 32'd0);
        chk("rst_stga", 32'(bus.stageA), 32'd0);
        #10 resetN = 1'b1;
        tick;

        // Stream three items with the consumer always ready.
        bus.outReady = 1'b1;
        drive(32'h11, 5'd1, 1'b1, 1'b1); #1 chk("s_irdy0", 32'(bus.inReady), 32'd1);
        tick;
        drive(32'h22, 5'd2, 1'b1, 1'b1); #1 chk("s_irdy1", 32'(bus.inReady), 32'd1);
        tick;
        drive(32'h33, 5'd3, 1'b0, 1'b1); #1 chk("s_irdy2", 32'(bus.inReady), 32'd1);
        tick;
        chk("s_early", 32'(bus.outValid), 32'd0);
        drive(32'h0, 5'd0, 1'b0, 1'b0);
        tick;
        chk("s_ov1", 32'(bus.outValid), 32'd1);
        chk("s_d1", bus.outData, 32'h11);
        chk("s_dst1", 32'(bus.outDest), 32'd1);
        chk("s_wr1", 32'(bus.outWrite), 32'd1);
        tick;
        chk("s_d2", bus.outData, 32'h22);
        chk("s_dst2", 32'(bus.outDest), 32'd2);
        tick;
        chk("s_d3", bus.outData, 32'h33);
        chk("s_wr3", 32'(bus.outWrite), 32'd0);
        tick;
        chk("s_end", 32'(bus.outValid), 32'd0);

        // Backpressure: fill 4, 5th stalls, then drain in order.
        bus.outReady = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(32'(k), 5'(k), 1'b1, 1'b1);
            #1 chk("bp_irdy", 32'(bus.inReady), 32'd1);
            tick;
        end
        drive(32'd5, 5'd5, 1'b1, 1'b1);
        #1 chk("bp_full", 32'(bus.inReady), 32'd0);
        chk("bp_head", bus.outData, 32'd1);
        tick;
        chk("bp_hold", bus.outData, 32'd1);
        chk("bp_full2", 32'(bus.inReady), 32'd0);
        bus.outReady = 1'b1;
        #1 chk("bp_pass", 32'(bus.inReady), 32'd1);
        tick;
        drive(32'h0, 5'd0, 1'b0, 1'b0);
        chk("bp_o2", bus.outData, 32'd2);
        for (int k = 3; k <= 5; k++) begin
            tick;
            chk("bp_on", bus.outData, 32'(k));
            chk("bp_ovn", 32'(bus.outValid), 32'd1);
        end
        tick;
        chk("bp_end", 32'(bus.outValid), 32'd0);

        // Flush stage 2 of a full, stalled chain.
        bus.outReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(32'h101 + 32'(k), 5'd4 + 5'(k), 1'b1, 1'b1);
            tick;
        end
        drive(32'h0, 5'd0, 1'b0, 1'b0);
        bus.flush = 4'b0100;
        #1 chk("fl_irdy", 32'(bus.inReady), 32'd1);
        chk("fl_ov", bus.outData, 32'h101);
        tick;
        bus.flush    = '0;
        bus.outReady = 1'b1;
        #1 chk("fl_o1", bus.outData, 32'h101);
        tick;
        chk("fl_o2", bus.outData, 32'h103);
        tick;
        chk("fl_o3", bus.outData, 32'h104);
        tick;
        chk("fl_end", 32'(bus.outValid), 32'd0);

        // Forwarding: s3=BBBB/8, s2=C/3, s1=AAAA/8, s0=D/0.
        bus.outReady = 1'b0;
        drive(32'hBBBB, 5'd8, 1'b1, 1'b1); tick;
        drive(32'h000C, 5'd3, 1'b1, 1'b1); tick;
        drive(32'hAAAA, 5'd8, 1'b1, 1'b1); tick;
        drive(32'h000D, 5'd0, 1'b1, 1'b1); tick;
        drive(32'h0, 5'd0, 1'b0, 1'b0);
        bus.srcA = 5'd8;
        bus.srcB = 5'd0;
        #1 chk("fw_hita", 32'(bus.hitA), 32'd1);
        chk("fw_fwda", bus.fwdA, 32'hAAAA);
        chk("fw_stga", 32'(bus.stageA), 32'd1);
        chk("fw_zero_hit", 32'(bus.hitB), 32'd0);
        chk("fw_zero_fwd", bus.fwdB, 32'd0);
        bus.srcB = 5'd3;
        #1 chk("fw_hitb", 32'(bus.hitB), 32'd1);
        chk("fw_fwdb", bus.fwdB, 32'hC);
        chk("fw_stgb", 32'(bus.stageB), 32'd2);
        bus.flush = 4'b0010;
        #1 chk("fw_fl1_fwd", bus.fwdA, 32'hBBBB);
        chk("fw_fl1_stg", 32'(bus.stageA), 32'd3);
        bus.flush = 4'b1010;
        #1 chk("fw_fl2_hit", 32'(bus.hitA), 32'd0);
        chk("fw_fl2_fwd", bus.fwdA, 32'd0);
        bus.flush = '0;
        bus.srcA  = 5'd9;
        #1 chk("fw_miss", 32'(bus.hitA), 32'd0);
        bus.outReady = 1'b1;
        tick; tick; tick; tick;
        chk("fw_drain", 32'(bus.outValid), 32'd0);

        // Refill with stage 1's item not writing.
        bus.outReady = 1'b0;
        drive(32'hBBBB, 5'd8, 1'b1, 1'b1); tick;
        drive(32'h000C, 5'd3, 1'b1, 1'b1); tick;
        drive(32'hAAAA, 5'd8, 1'b0, 1'b1); tick;
        drive(32'h000D, 5'd0, 1'b1, 1'b1); tick;
        drive(32'h0, 5'd0, 1'b0, 1'b0);
        bus.srcA = 5'd8;
        #1 chk("fw_nw_hit", 32'(bus.hitA), 32'd1);
        chk("fw_nw_fwd", bus.fwdA, 32'hBBBB);
        chk("fw_nw_stg", 32'(bus.stageA), 32'd3);

        // Asynchronous reset between edges while full.
        #1 resetN = 1'b0;
        #1 chk("ar_ovld", 32'(bus.outValid), 32'd0);
        chk("ar_irdy", 32'(bus.inReady), 32'd1);
        chk("ar_hita", 32'(bus.hitA), 32'd0);
        chk("ar_fwda", bus.fwdA, 32'd0);
        #1 resetN = 1'b1;
        bus.outReady = 1'b1;
        drive(32'h5A, 5'd7, 1'b1, 1'b1);
        tick;
        drive(32'h0, 5'd0, 1'b0, 1'b0);
        tick;
        tick;
        chk("ar_early", 32'(bus.outValid), 32'd0);
        tick;
        chk("ar_ov", 32'(bus.outValid), 32'd1);
        chk("ar_d", bus.outData, 32'h5A);
        chk("ar_dst", 32'(bus.outDest), 32'd7);
        tick;
        chk("ar_end", 32'(bus.outValid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
